seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 3-bit Mealy/Moore sensor FSMs.
- Samples one bit per enabled clock on `a`.
- Tracks the length of the longest matched prefix of a parameter-defined pattern, with overlapping or non-overlapping match mode.
- Pulses `z` on each match, keeps a saturating match counter, and exposes its state on `y` for debug.

Parameters:
- PATTERN_LEN, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1101: pattern bits, width PATTERN_LEN. PATTERN[PATTERN_LEN-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = search restarts from scratch after a match.
- CNT_W, 8: width of the match counter.
- ST_W, $clog2(PATTERN_LEN+1): width of the state/debug bus (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; `a` is consumed only when en=1.
- clr  in  1  synchronous clear of state and counter.
- a  in  1  serial input bit.
- y  out  ST_W  current state = number of pattern bits currently matched (0..PATTERN_LEN).
- z  out  1  match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset values (asynchronous on reset=1): y=0, z=0, match_cnt=0.
- Priority: reset > clr > en. If clr=1, then at the next edge y=0 and match_cnt=0, and z is forced 0 in both output modes.
- If en=0 (and clr=0), y and match_cnt hold and z=0.
- State k means the last k consumed bits equal PATTERN[LEN-1 -: k], i.e. the first k pattern bits.
- Transition from state k<LEN on bit b:
  - If b == PATTERN[LEN-1-k], go to k+1.
  - Otherwise go to the longest j<=k such that the last j bits (including b) equal the first j pattern bits (KMP failure rule).
  - The transition table is computed at elaboration from PATTERN. No hard-coded per-pattern table.
- From state LEN:
  - OVERLAP=1: behave as the failure state of the full pattern (longest proper prefix that is also a suffix), then apply b.
  - OVERLAP=0: behave as state 0, then apply b.
- A match is any enabled edge whose next state equals LEN.
- match_cnt increments by 1 on each match edge and saturates at 2^CNT_W-1 (no wrap).
- Reset asserted mid-pattern discards partial progress immediately. After release, detection restarts from state 0.

Optional Feature:
- Macro: SEQ_DET_MEALY_OUT_EN.
- Defined: z is combinational (Mealy) — z = en & ~clr & (next_state == LEN). z asserts in the same cycle the final bit is presented on `a`.
- Undefined (default): z is Moore — z = (y == LEN), registered. z asserts for the one cycle after the match edge. If the state leaves LEN, or en=0 holds the state at LEN, z is 1 only on the first cycle.
- The y sequence and match_cnt timing are identical in both builds.

Test Plan:
- Defaults, OVERLAP=1, en=1; a stream 1,1,0,1,1,0,1 after reset release → y = 1,2,3,4,2,3,4. Two z pulses (Moore: cycles after bits 4 and 7). match_cnt ends at 2.
- Same stream, OVERLAP=0 → y = 1,2,3,4,1,0,1. One z pulse. match_cnt = 1.
- en toggled low for 3 cycles between bits 2 and 3 of 1101, with `a` toggling while en=0 → y holds at 2 throughout the gap. Match still detected after bit 4. No z while en=0.
- Assert reset asynchronously (between edges) while y=3 → y=0, z=0, match_cnt=0 immediately without a clock edge. Next 1101 gives exactly one match.
- CNT_W=2, stream 1101 repeated 5 times (non-overlap) → match_cnt = 1,2,3,3,3 (saturates). z still pulses 5 times.
- Build with SEQ_DET_MEALY_OUT_EN → z high during the cycle the 4th bit of 1101 is on `a`, one cycle earlier than the Moore build. clr=1 on that cycle suppresses z and leaves y=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP-style prefix tracking and a saturating match counter.
// Optional macro SEQ_DET_MEALY_OUT_EN: combinational (Mealy) z instead of the registered (Moore) z.
module seq_detector_param #(
    parameter int unsigned            PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int unsigned            CNT_W       = 8,
    parameter int unsigned            ST_W        = $clog2(PATTERN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    output logic [ST_W-1:0]  y,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned     NROWS = 1 << ST_W;
    localparam logic [ST_W-1:0] LEN_S = ST_W'(PATTERN_LEN);

    // Pattern bit in arrival order: index 0 is the first bit received.
    function automatic logic pat_bit(input int unsigned t);
        logic [PATTERN_LEN-1:0] v;
        v = PATTERN >> (PATTERN_LEN - 1 - t);
        return v[0];
    endfunction

    // Longest prefix of the pattern that is a suffix of (first k pattern bits, b).
    function automatic logic [ST_W-1:0] kmp_next(input int unsigned k, input logic b);
        int unsigned best;
        logic        ok;
        logic        sb;
        best = 0;
        for (int unsigned j = 1; j <= PATTERN_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int unsigned t = 0; t < PATTERN_LEN; t++) begin
                    if (t < j) begin
                        sb = ((k + 1 - j + t) == k) ? b : pat_bit(k + 1 - j + t);
                        if (sb != pat_bit(t)) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return ST_W'(best);
    endfunction

    logic [ST_W-1:0] nxt0 [NROWS];
    logic [ST_W-1:0] nxt1 [NROWS];

    // Row LEN folds in the overlap policy; unreachable rows fall back to state 0.
    for (genvar k = 0; k < NROWS; k++) begin : g_row
        localparam int unsigned SRC = (k == PATTERN_LEN) ? (OVERLAP ? PATTERN_LEN : 0)
                                    : ((k < PATTERN_LEN) ? k : 0);
        localparam logic [ST_W-1:0] N0 = kmp_next(SRC, 1'b0);
        localparam logic [ST_W-1:0] N1 = kmp_next(SRC, 1'b1);
        assign nxt0[k] = N0;
        assign nxt1[k] = N1;
    end

    logic [ST_W-1:0] nxt;
    logic            hit;

    always_comb begin
        nxt = a ? nxt1[y] : nxt0[y];
        hit = (nxt == LEN_S);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            match_cnt <= '0;
`ifndef SEQ_DET_MEALY_OUT_EN
            z         <= 1'b0;
`endif
        end else if (clr) begin
            y         <= '0;
            match_cnt <= '0;
`ifndef SEQ_DET_MEALY_OUT_EN
            z         <= 1'b0;
`endif
        end else begin
`ifndef SEQ_DET_MEALY_OUT_EN
            z <= en & hit;
`endif
            if (en) begin
                y <= nxt;
                if (hit && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_DET_MEALY_OUT_EN
    assign z = en & ~clr & hit;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap / non-overlap, enable gaps, async reset, clr, saturation.
// Builds with or without SEQ_DET_MEALY_OUT_EN; z is sampled before the edge for Mealy, after it for Moore.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, en, clr, a;
    logic [2:0] y_ov, y_no, y_sat;
    logic       z_ov, z_no, z_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;
    logic       zp_ov, zp_no, zp_sat;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a),
        .y(y_ov), .z(z_ov), .match_cnt(c_ov));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a),
        .y(y_no), .z(z_no), .match_cnt(c_no));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a),
        .y(y_sat), .z(z_sat), .match_cnt(c_sat));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one bit, capture combinational z before the edge, then advance past the edge.
    task automatic step(input logic ai, input logic ei, input logic ci);
        a   = ai;
        en  = ei;
        clr = ci;
        #1;
        zp_ov  = z_ov;
        zp_no  = z_no;
        zp_sat = z_sat;
        @(posedge clk);
        #1;
    endtask

    function automatic logic zsel(input logic pre, input logic post);
`ifdef SEQ_DET_MEALY_OUT_EN
        return pre;
`else
        return post;
`endif
    endfunction

    logic s1    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   e_yov [7] = '{1, 2, 3, 4, 2, 3, 4};
    int   e_yno [7] = '{1, 2, 3, 4, 1, 0, 1};
    int   e_zov [7] = '{0, 0, 0, 1, 0, 0, 1};
    int   e_zno [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic pat   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int   e_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        a     = 1'b0;
        #12;
        check("rst_y", y_ov, 0);
        check("rst_z", z_ov, 0);
        check("rst_cnt", c_ov, 0);
        reset = 1'b0;

        // 1101101 through overlapping and non-overlapping instances
        for (int i = 0; i < 7; i++) begin
            step(s1[i], 1'b1, 1'b0);
            check("ov_y", y_ov, e_yov[i]);
            check("ov_z", zsel(zp_ov, z_ov), e_zov[i]);
            check("no_y", y_no, e_yno[i]);
            check("no_z", zsel(zp_no, z_no), e_zno[i]);
        end
        check("ov_cnt", c_ov, 2);
        check("no_cnt", c_no, 1);

        step(1'b0, 1'b1, 1'b1);
        check("clr_y", y_ov, 0);
        check("clr_cnt", c_ov, 0);
        check("clr_z", zsel(zp_ov, z_ov), 0);

        // enable gap between bits 2 and 3 with a toggling
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("gap_pre_y", y_ov, 2);
        for (int g = 0; g < 3; g++) begin
            step((g == 1), 1'b0, 1'b0);
            check("gap_y", y_ov, 2);
            check("gap_z", zsel(zp_ov, z_ov), 0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("gap_y3", y_ov, 3);
        step(1'b1, 1'b1, 1'b0);
        check("gap_y4", y_ov, 4);
        check("gap_z4", zsel(zp_ov, z_ov), 1);
        check("gap_cnt", c_ov, 1);

        // en=0 holding at LEN: z only on the first cycle
        step(1'b1, 1'b0, 1'b0);
        check("hold_y", y_ov, 4);
        check("hold_z", zsel(zp_ov, z_ov), 0);
        check("hold_cnt", c_ov, 1);

        // KMP fallbacks: 4 -1-> 2, 2 -1-> 2, 2 -0-> 3
        step(1'b1, 1'b1, 1'b0);
        check("kmp_4_1", y_ov, 2);
        step(1'b1, 1'b1, 1'b0);
        check("kmp_2_1", y_ov, 2);
        step(1'b0, 1'b1, 1'b0);
        check("kmp_2_0", y_ov, 3);

        // asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        check("arst_y", y_ov, 0);
        check("arst_z", z_ov, 0);
        check("arst_cnt", c_ov, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(pat[i], 1'b1, 1'b0);
            check("arst_seq_y", y_ov, i + 1);
        end
        check("arst_seq_cnt", c_ov, 1);

        // clr on the final bit suppresses the match
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("sup_pre_y", y_ov, 3);
        step(1'b1, 1'b1, 1'b1);
        check("sup_z", zsel(zp_ov, z_ov), 0);
        check("sup_y", y_ov, 0);
        check("sup_cnt", c_ov, 0);

        // 2-bit counter saturation, non-overlapping
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) step(pat[i], 1'b1, 1'b0);
            check("sat_cnt", c_sat, e_sat[r]);
            check("sat_z", zsel(zp_sat, z_sat), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
